// File: rtl/pdp_layer_sched_if.sv
// rtl/pdp_layer_sched_if.sv - valid/ready beat bundle carrying the 20-bit PDP payload
interface pdp_layer_sched_if;
    logic        pvld;
    logic        prdy;
    logic [19:0] pd;

    modport master (output pvld, output pd, input prdy);
    modport slave  (input pvld, input pd, output prdy);
endinterface

// File: rtl/pdp_layer_sched.sv
// rtl/pdp_layer_sched.sv - PDP layer scheduler: ping-pong group sequencing and RDMA beat gating
module pdp_layer_sched (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    reg2dp_op_en0,
    input  logic                    reg2dp_op_en1,
    input  logic                    reg2dp_flying_mode,
    pdp_layer_sched_if.slave        rdma_in,
    pdp_layer_sched_if.master       core_out,
    input  logic                    wdma_done,
    output logic                    dp2reg_consumer,
    output logic [1:0]              dp2reg_status_0,
    output logic [1:0]              dp2reg_status_1,
    output logic [1:0]              op_en_clr,
    output logic [1:0]              pdp_done_intr,
    output logic [31:0]             dp2reg_beat_num,
    output logic                    dp2reg_sched_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic        consumer;
    logic        run_gate;
    logic [31:0] beat_cnt;
    logic [31:0] beat_num;
    logic        sched_err;

    logic        gate;
    logic        beat_acc;
    logic        layer_end;
    logic        consumer_op_en;
    logic        layer_done;
    logic [31:0] beat_cnt_inc;
    logic [31:0] beat_cnt_nxt;
    logic [1:0]  done_vec;

    // run_gate mirrors state==RUN as a flop so the data path never sees decode glitches
    assign gate           = run_gate & reg2dp_flying_mode;
    assign core_out.pvld  = rdma_in.pvld & gate;
    assign rdma_in.prdy   = core_out.prdy & gate;
    assign core_out.pd    = rdma_in.pd;

    assign beat_acc       = rdma_in.pvld & rdma_in.prdy;
    assign layer_end      = beat_acc & rdma_in.pd[19] & rdma_in.pd[15];
    assign consumer_op_en = consumer ? reg2dp_op_en1 : reg2dp_op_en0;
    assign layer_done     = wdma_done & (state != ST_IDLE);

    assign beat_cnt_inc   = (beat_cnt == 32'hFFFF_FFFF) ? beat_cnt : beat_cnt + 32'd1;
    assign beat_cnt_nxt   = beat_acc ? beat_cnt_inc : beat_cnt;

    assign done_vec       = consumer ? 2'b10 : 2'b01;
    assign pdp_done_intr  = layer_done ? done_vec : 2'b00;
    assign op_en_clr      = layer_done ? done_vec : 2'b00;

    assign dp2reg_consumer  = consumer;
    assign dp2reg_beat_num  = beat_num;
    assign dp2reg_sched_err = sched_err;

    always_comb begin
        dp2reg_status_0 = 2'd0;
        dp2reg_status_1 = 2'd0;
        if (!consumer && state != ST_IDLE) begin
            dp2reg_status_0 = 2'd1;
        end else if (reg2dp_op_en0) begin
            dp2reg_status_0 = 2'd2;
        end
        if (consumer && state != ST_IDLE) begin
            dp2reg_status_1 = 2'd1;
        end else if (reg2dp_op_en1) begin
            dp2reg_status_1 = 2'd2;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state     <= ST_IDLE;
            consumer  <= 1'b0;
            run_gate  <= 1'b0;
            beat_cnt  <= 32'd0;
            beat_num  <= 32'd0;
            sched_err <= 1'b0;
        end else begin
            if (wdma_done && state == ST_IDLE) begin
                sched_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (consumer_op_en) begin
                        state    <= ST_RUN;
                        run_gate <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wdma_done) begin
                        state    <= ST_IDLE;
                        run_gate <= 1'b0;
                        consumer <= ~consumer;
                        beat_num <= beat_cnt_nxt;
                        beat_cnt <= 32'd0;
                    end else begin
                        beat_cnt <= beat_cnt_nxt;
                        // close the gate right after the layer-end beat so the next layer's beats wait
                        if (layer_end) begin
                            state    <= ST_DRAIN;
                            run_gate <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wdma_done) begin
                        state    <= ST_IDLE;
                        consumer <= ~consumer;
                        beat_num <= beat_cnt;
                        beat_cnt <= 32'd0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    run_gate <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pdp_layer_sched.md
# pdp_layer_sched

Layer scheduler for the PDP core input path. Sequences layers across the two ping-pong register groups and tracks which group is the current consumer. Gates the RDMA-to-core beat stream so it flows only while an off-fly layer is running, and closes each layer on the write-DMA done pulse with per-group interrupts and op_en clears. Sits between PDP RDMA and the NaN pre-processing stage, alongside the register file.

## Interface
- No parameters; payload width fixed at 20 bits (8-bit data + 12-bit info).
- nvdla_core_clk  in  1  core clock; one clock, all logic on rising edge.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- reg2dp_op_en0 / reg2dp_op_en1  in  1 each  group 0/1 layer enable (level).
- reg2dp_flying_mode  in  1  0 = on-fly (input from SDP, RDMA unused); 1 = off-fly (input from RDMA).
- rdma_in_pvld  in  1  RDMA beat valid.
- rdma_in_prdy  out  1  RDMA beat ready.
- rdma_in_pd  in  20  RDMA beat payload; bit19 = cube end, bit15 = last surface.
- core_out_pvld  out  1  beat valid toward NaN stage.
- core_out_prdy  in  1  NaN stage ready.
- core_out_pd  out  20  equals rdma_in_pd.
- wdma_done  in  1  single-cycle layer-complete pulse from PDP WDMA.
- dp2reg_consumer  out  1  group currently owned/next to run.
- dp2reg_status_0 / dp2reg_status_1  out  2 each  0 idle, 1 running, 2 pending.
- op_en_clr  out  2  one-cycle pulse; bit g clears reg2dp_op_en of group g.
- pdp_done_intr  out  2  one-cycle pulse per completed group.
- dp2reg_beat_num  out  32  beats accepted in last completed layer.
- dp2reg_sched_err  out  1  sticky: wdma_done received while IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset → IDLE, consumer 0.
- IDLE: op_en of consumer group high → RUN next cycle. Other group's op_en ignored.
- RUN: gate = reg2dp_flying_mode. Accepted beat (pvld & prdy) with pd[19] & pd[15] → DRAIN.
- On-fly mode: gate closed in all states; a layer ends only by wdma_done while in RUN.
- DRAIN: gate closed; waits for wdma_done.
- Completion: wdma_done in RUN or DRAIN. Same cycle: pdp_done_intr[consumer] and op_en_clr[consumer] pulse; consumer toggles; state → IDLE.
- Layer-end beat and wdma_done in the same RUN cycle → completion directly (no DRAIN).
- wdma_done in IDLE: no state change, no pulses, dp2reg_sched_err set.
- op_en deassertion of the consumer during RUN/DRAIN is ignored; the layer runs to completion.
- Beat counter (32-bit, saturates at 0xFFFF_FFFF) increments per accepted beat in RUN. At completion, counter value including any same-cycle beat → dp2reg_beat_num; counter → 0.
- Status g: 1 if consumer==g and state!=IDLE; else 2 if op_en_g; else 0.

## Timing
- Data path combinational, zero latency: core_out_pvld = rdma_in_pvld & gate; rdma_in_prdy = core_out_prdy & gate; core_out_pd = rdma_in_pd.
- Gate is a registered state decode; it closes the cycle after the layer-end beat is accepted, so no beat of the next layer passes.
- IDLE→RUN one cycle after op_en seen. Back-to-back: pending group starts 2 cycles after completion pulse (IDLE 1 cycle, then RUN).
- Reset values: prdy/pvld 0, consumer 0, status 0/0 unless op_en high (status combinational), op_en_clr 0, intr 0, beat_num 0, err 0.
- Async reset mid-layer: immediate return to IDLE, gate closed, counter cleared; no pulses emitted.

## Test plan
- Off-fly single layer: op_en0=1, 5 beats, last with pd[19]=pd[15]=1, then wdma_done → intr=2'b01, op_en_clr=2'b01, beat_num=5, consumer=1.
- Back-to-back: op_en0=op_en1=1, two off-fly layers of 3 and 4 beats → intr 01 then 10, beat_num 3 then 4; no beat after layer-end passes before group 1 RUN.
- Backpressure: core_out_prdy=0 for 10 cycles mid-layer → rdma_in_prdy=0, count unchanged; the layer-end beat held under stall still transitions to DRAIN only on acceptance.
- On-fly: flying_mode=0, op_en1 after consumer=1, RDMA pvld=1 → rdma_in_prdy stays 0; wdma_done → intr=2'b10, beat_num=0.
- Simultaneous: layer-end beat and wdma_done in the same cycle → completion that cycle, beat_num includes that beat, state IDLE.
- Error/reset: wdma_done in IDLE → sched_err=1, no intr; assert rstn low mid-RUN → all outputs reset values, err cleared.
